// File: rtl/c16_muldiv.sv
// Sequential multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per cycle, with sign handling before and after the iteration loop.
module c16_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div_zero,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               is_signed;
    logic               dz;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign fsm_state = state;

    assign sa    = is_signed & opa[WIDTH-1];
    assign sb    = is_signed & opb[WIDTH-1];
    assign abs_a = sa ? (~opa + 1'b1) : opa;
    assign abs_b = sb ? (~opb + 1'b1) : opb;

    // Multiply: hi accumulates, lo holds the remaining multiplier bits.
    assign mul_sum   = {1'b0, hi} + ({1'b0, mcand} & {(WIDTH+1){lo[0]}});
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand};

    assign prod_fix = neg_res ? (~{hi, lo} + 1'b1) : {hi, lo};
    assign q_fix    = neg_res ? (~lo + 1'b1) : lo;
    assign r_fix    = neg_rem ? (~hi + 1'b1) : hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            res_lo    <= '0;
            res_hi    <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            dz        <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        opa       <= a;
                        opb       <= b;
                        is_div    <= op_div;
                        is_signed <= op_signed;
                        dz        <= 1'b0;
                        state     <= PREP;
                    end
                end
                PREP: begin
                    busy    <= 1'b1;
                    hi      <= '0;
                    cnt     <= CNT_W'(WIDTH);
                    neg_res <= sa ^ sb;
                    neg_rem <= sa;
                    if (is_div) begin
                        lo    <= abs_a;
                        mcand <= abs_b;
                        if (opb == '0) begin
                            dz    <= 1'b1;
                            state <= FIX;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        lo    <= abs_b;
                        mcand <= abs_a;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        hi <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], ~div_trial[WIDTH]};
                    end else begin
                        hi <= mul_sum[WIDTH:1];
                        lo <= {mul_sum[0], lo[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (dz) begin
                        res_lo   <= '1;
                        res_hi   <= opa;
                        div_zero <= 1'b1;
                    end else if (is_div) begin
                        res_lo   <= q_fix;
                        res_hi   <= r_fix;
                        div_zero <= 1'b0;
                    end else begin
                        res_lo   <= prod_fix[WIDTH-1:0];
                        res_hi   <= prod_fix[2*WIDTH-1:WIDTH];
                        div_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c16_muldiv.sv
// Directed bench for c16_muldiv at WIDTH=16 and WIDTH=8 with hand-computed results.
module tb_c16_muldiv;

    logic        clk;
    logic        rst16, rst8;
    logic        start16, start8;
    logic        div16, div8, sgn16, sgn8;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic        busy16, done16, dz16, busy8, done8, dz8;
    logic [15:0] lo16, hi16;
    logic [7:0]  lo8, hi8;
    logic [1:0]  st16, st8;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] r_lo, r_hi, r_dz;
    int          lat, bcnt;
    logic [31:0] timed_out;

    c16_muldiv #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clk(clk), .reset(rst16), .start(start16), .op_div(div16), .op_signed(sgn16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .res_lo(lo16), .res_hi(hi16),
        .div_zero(dz16), .fsm_state(st16)
    );

    c16_muldiv #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .op_div(div8), .op_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .res_lo(lo8), .res_hi(hi8),
        .div_zero(dz8), .fsm_state(st8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic dv, input logic sg,
                         input logic [31:0] x, input logic [31:0] y);
        if (w == 16) begin
            start16 = s; div16 = dv; sgn16 = sg; a16 = x[15:0]; b16 = y[15:0];
        end else begin
            start8 = s; div8 = dv; sgn8 = sg; a8 = x[7:0]; b8 = y[7:0];
        end
    endtask

    // One operation; lat = edges from start edge to done, bcnt = cycles with busy high.
    task automatic run_op(input int w, input logic dv, input logic sg,
                          input logic [31:0] x, input logic [31:0] y, input bit mid);
        int  n;
        int  bc;
        logic d;
        logic bz;
        @(negedge clk);
        drive(w, 1'b1, dv, sg, x, y);
        @(posedge clk);
        n = 0; bc = 0; timed_out = 1;
        while (n < 60) begin
            @(negedge clk);
            if (n == 0) drive(w, 1'b0, dv, sg, x, y);
            if (mid && n == 5) drive(w, 1'b1, ~dv, ~sg, 32'h1, 32'h1);
            if (mid && n == 6) drive(w, 1'b0, ~dv, ~sg, 32'h1, 32'h1);
            d  = (w == 16) ? done16 : done8;
            bz = (w == 16) ? busy16 : busy8;
            if (bz) bc++;
            if (d) begin
                timed_out = 0;
                break;
            end
            @(posedge clk);
            n++;
        end
        lat = n; bcnt = bc;
        r_lo = (w == 16) ? {16'h0, lo16} : {24'h0, lo8};
        r_hi = (w == 16) ? {16'h0, hi16} : {24'h0, hi8};
        r_dz = (w == 16) ? {31'h0, dz16} : {31'h0, dz8};
        chk("no_timeout", timed_out, 32'h0);
    endtask

    task automatic count_dones(input int w, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ((w == 16) ? done16 : done8) cnt++;
        end
    endtask

    initial begin
        int nd;
        int gap;
        rst16 = 1; rst8 = 1;
        drive(16, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(8,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst16_flags", {29'h0, busy16, done16, dz16}, 32'h0);
        chk("rst16_res", {lo16, hi16}, 32'h0);
        chk("rst16_state", {30'h0, st16}, 32'h0);
        chk("rst8_flags", {29'h0, busy8, done8, dz8}, 32'h0);
        chk("rst8_res", {16'h0, lo8, hi8}, 32'h0);
        rst16 = 0; rst8 = 0;

        // WIDTH=16 unsigned multiply with latency and busy length.
        run_op(16, 0, 0, 32'h1234, 32'h0100, 0);
        chk("mul_u_hi", r_hi, 32'h0012);
        chk("mul_u_lo", r_lo, 32'h3400);
        chk("mul_u_lat", lat, 18);
        chk("mul_u_busy", bcnt, 17);
        chk("mul_u_dz", r_dz, 0);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, done16}, 0);
        chk("busy_low_after", {31'h0, busy16}, 0);
        chk("res_hold", {16'h0, lo16}, 32'h3400);

        run_op(16, 0, 1, 32'hFFFD, 32'h0007, 0);
        chk("mul_s_hi", r_hi, 32'hFFFF);
        chk("mul_s_lo", r_lo, 32'hFFEB);
        run_op(16, 0, 0, 32'hFFFF, 32'hFFFF, 0);
        chk("mul_max_hi", r_hi, 32'hFFFE);
        chk("mul_max_lo", r_lo, 32'h0001);

        run_op(16, 1, 1, 32'hFFF9, 32'h0002, 0);
        chk("div_s_q", r_lo, 32'hFFFD);
        chk("div_s_r", r_hi, 32'hFFFF);
        chk("div_s_lat", lat, 18);
        run_op(16, 1, 0, 32'hFFF9, 32'h0002, 0);
        chk("div_u_q", r_lo, 32'h7FFC);
        chk("div_u_r", r_hi, 32'h0001);

        run_op(16, 1, 0, 32'h0005, 32'h0000, 0);
        chk("dz_u_lo", r_lo, 32'hFFFF);
        chk("dz_u_hi", r_hi, 32'h0005);
        chk("dz_u_flag", r_dz, 1);
        chk("dz_u_lat", lat, 2);
        run_op(16, 1, 1, 32'hFFF9, 32'h0000, 0);
        chk("dz_s_lo", r_lo, 32'hFFFF);
        chk("dz_s_hi", r_hi, 32'hFFF9);
        chk("dz_s_flag", r_dz, 1);
        run_op(16, 0, 1, 32'h0003, 32'h0004, 0);
        chk("mul_clr_dz", r_dz, 0);
        chk("mul_small_lo", r_lo, 32'h000C);

        // Overflow divide, with a start pulse and operand changes mid-RUN.
        run_op(16, 1, 1, 32'h8000, 32'hFFFF, 1);
        chk("ovf_q", r_lo, 32'h8000);
        chk("ovf_r", r_hi, 32'h0000);
        chk("ovf_dz", r_dz, 0);
        chk("ovf_lat", lat, 18);
        count_dones(16, 25, nd);
        chk("mid_start_ignored", nd, 0);
        chk("ovf_hold", {lo16, hi16}, 32'h8000_0000);

        // Start held high: ignored in FIX, accepted the cycle after done.
        @(negedge clk);
        drive(16, 1'b1, 1'b0, 1'b0, 32'h0002, 32'h0003);
        nd = 0;
        for (int i = 0; i < 40 && !done16; i++) @(negedge clk);
        chk("b2b_first_done", {31'h0, done16}, 1);
        gap = 0;
        @(negedge clk);
        for (int i = 0; i < 40 && !done16; i++) begin
            gap++;
            @(negedge clk);
        end
        drive(16, 1'b0, 1'b0, 1'b0, 32'h0002, 32'h0003);
        chk("b2b_gap", gap + 1, 19);
        chk("b2b_res", {16'h0, lo16}, 32'h0006);
        count_dones(16, 25, nd);
        chk("b2b_no_third", nd, 0);

        // Reset five cycles into a multiply aborts it.
        @(negedge clk);
        drive(16, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0100);
        @(negedge clk);
        start16 = 0;
        repeat (5) @(negedge clk);
        rst16 = 1;
        start16 = 1;
        @(negedge clk);
        chk("rst_mid_busy", {31'h0, busy16}, 0);
        chk("rst_mid_done", {31'h0, done16}, 0);
        chk("rst_mid_state", {30'h0, st16}, 0);
        rst16 = 0;
        start16 = 0;
        count_dones(16, 30, nd);
        chk("rst_no_done", nd, 0);
        run_op(16, 0, 0, 32'h1234, 32'h0100, 0);
        chk("after_rst_lo", r_lo, 32'h3400);
        chk("after_rst_hi", r_hi, 32'h0012);

        // WIDTH=8 repeats.
        run_op(8, 0, 0, 32'h12, 32'h10, 0);
        chk("w8_mul_u_hi", r_hi, 32'h01);
        chk("w8_mul_u_lo", r_lo, 32'h20);
        chk("w8_mul_u_lat", lat, 10);
        chk("w8_mul_u_busy", bcnt, 9);
        run_op(8, 0, 1, 32'hFD, 32'h07, 0);
        chk("w8_mul_s", {r_hi[7:0], r_lo[7:0]}, 32'hFFEB);
        run_op(8, 0, 0, 32'hFF, 32'hFF, 0);
        chk("w8_mul_max", {r_hi[7:0], r_lo[7:0]}, 32'hFE01);
        run_op(8, 1, 1, 32'hF9, 32'h02, 0);
        chk("w8_div_s", {r_hi[7:0], r_lo[7:0]}, 32'hFFFD);
        run_op(8, 1, 0, 32'hF9, 32'h02, 0);
        chk("w8_div_u", {r_hi[7:0], r_lo[7:0]}, 32'h017C);
        run_op(8, 1, 0, 32'h05, 32'h00, 0);
        chk("w8_dz", {r_dz[7:0], r_hi[7:0], r_lo[7:0]}, 32'h0105FF);
        chk("w8_dz_lat", lat, 2);
        run_op(8, 1, 1, 32'h80, 32'hFF, 1);
        chk("w8_ovf", {r_dz[7:0], r_hi[7:0], r_lo[7:0]}, 32'h000080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
